minmax_job_scheduler: RTL and testbench
=======================================

MINMAX_JOB_SCHEDULER -- requirements
Module: minmax_job_scheduler

Interface
REQ-001 Parameter ADDR_W, default 16, sample/result memory address width.
REQ-002 Parameter DATA_W, default 32, signed audio sample width.
REQ-003 Parameter LEN_W, default 16, sample-count and interval-length width.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  2  per-requester job request; bit r is requester r.
REQ-007 req_ready  out  2  job accepted when req_valid[r] & req_ready[r].
REQ-008 req_base  in  2*ADDR_W  packed; first sample address per requester.
REQ-009 req_count  in  2*LEN_W  packed; total samples per job.
REQ-010 req_interval  in  2*LEN_W  packed; samples per interval.
REQ-011 req_res_base  in  2*ADDR_W  packed; first result address per requester.
REQ-012 mem_rd_en, mem_rd_addr  out  1, ADDR_W  sample RAM read; data returns next cycle.
REQ-013 mem_rd_data  in  DATA_W  sample RAM read data.
REQ-014 eng_start  out  1  one-cycle pulse; shared min/max engine reinitialises min/max.
REQ-015 eng_sample_valid, eng_sample, eng_last  out  1, DATA_W, 1  sample stream to engine; eng_last marks the final sample of an interval.
REQ-016 eng_result_valid, eng_min, eng_max  in  1, DATA_W, DATA_W  engine result for the interval.
REQ-017 res_wr_en, res_wr_addr, res_wr_data  out  1, ADDR_W, 2*DATA_W  result write; data = {max, min}.
REQ-018 done, err  out  2, 2  one-cycle per-requester completion/error pulses.
REQ-019 busy, grant_id  out  1, 1  job in progress; requester owning the engine.

Function
REQ-020 States SHALL be IDLE, ARB, INT_START, FETCH, WAIT_RES, WRITE, FINISH.
REQ-021 IDLE: any req_valid -> ARB next cycle.
REQ-022 ARB: round-robin; on tie the requester not granted last wins; single valid requester wins outright.
REQ-023 ARB: req_ready[g] high exactly one cycle; job fields latched that cycle; grant_id=g; busy=1 until FINISH exits.
REQ-024 Requesters SHALL hold req_valid and fields stable until ready; a requester dropping valid before ready forfeits arbitration with no error.
REQ-025 Job with count=0 or interval=0: err[g] pulses 1 cycle after acceptance, no memory/engine/result activity, return to IDLE, no done.
REQ-026 INT_START: eng_start one cycle; interval index k starts at 0.
REQ-027 FETCH: one read per cycle, addresses base+j for j = k*interval .. min((k+1)*interval, count)-1; eng_sample_valid/eng_sample follow each read by exactly 1 cycle.
REQ-028 Final interval SHALL be short when count mod interval != 0; eng_last on its last sample.
REQ-029 WAIT_RES: wait unbounded for eng_result_valid; eng_result_valid outside WAIT_RES ignored.
REQ-030 WRITE: res_wr_en one cycle, res_wr_addr = res_base+k, res_wr_data = {eng_max, eng_min} captured on eng_result_valid.
REQ-031 After WRITE: samples remain -> INT_START with k+1; else FINISH.
REQ-032 FINISH: done[g] pulse one cycle, busy=0, last-grant pointer = g, -> IDLE (ARB next cycle if any req_valid).
REQ-033 Address arithmetic SHALL wrap modulo 2^ADDR_W; no error on wrap.
REQ-034 At most one job in flight; other requester waits with req_ready low.

Reset
REQ-035 reset SHALL force IDLE; all outputs 0; last-grant pointer = 1 so requester 0 wins the first tie.
REQ-036 reset mid-job SHALL discard the job with no done/err pulse and no further writes.

Configuration
REQ-037 Macro MINMAX_SCHED_TIMEOUT_EN defined: WAIT_RES beyond 256 cycles aborts job, err[g] pulse, no write, -> IDLE; undefined: wait unbounded, err only per REQ-025.

Verification
REQ-038 req0 base 0x10, count 20, interval 10, res_base 0x80, engine 2-cycle latency -> 20 reads 0x10..0x23, two eng_start, writes 0x80,0x81, done[0] once.
REQ-039 Both valid same cycle after reset -> req0 granted first, req1 second; next tie grants req0 (alternation).
REQ-040 count 25, interval 10 -> intervals 10,10,5; eng_last on samples 9,19,24; three writes.
REQ-041 req1 interval 0 -> err[1] pulse, zero mem_rd_en, zero res_wr_en, no done.
REQ-042 reset asserted mid-FETCH -> outputs 0 asynchronously, no done; new job after release runs normally.
REQ-043 MINMAX_SCHED_TIMEOUT_EN defined, engine silent -> err pulse 256 cycles into WAIT_RES; undefined -> busy stays 1.

Source files
------------

// File: rtl/minmax_job_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | minmax_job_scheduler                                                       |
// | Arbitrates two requesters onto one min/max engine. Each job streams its     |
// | samples interval by interval and writes one {max,min} result per interval. |
// | Optional build macro: MINMAX_SCHED_TIMEOUT_EN (abort a silent engine wait) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module minmax_job_scheduler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*ADDR_W-1:0]   req_base,
  input  logic [2*LEN_W-1:0]    req_count,
  input  logic [2*LEN_W-1:0]    req_interval,
  input  logic [2*ADDR_W-1:0]   req_res_base,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  eng_start,
  output logic                  eng_sample_valid,
  output logic [DATA_W-1:0]     eng_sample,
  output logic                  eng_last,
  input  logic                  eng_result_valid,
  input  logic [DATA_W-1:0]     eng_min,
  input  logic [DATA_W-1:0]     eng_max,
  output logic                  res_wr_en,
  output logic [ADDR_W-1:0]     res_wr_addr,
  output logic [2*DATA_W-1:0]   res_wr_data,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    INT_START = 3'd2,
    FETCH     = 3'd3,
    WAIT_RES  = 3'd4,
    WRITE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

  localparam logic [LEN_W:0]   POS_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] K_ONE   = LEN_W'(1);

  state_t              state_q, state_d;
  logic                grant_q, last_q, grant_d;
  logic [ADDR_W-1:0]   base_q, rbase_q;
  logic [LEN_W-1:0]    count_q, itv_q, k_q;
  logic [LEN_W:0]      pos_q, end_q, end_d, end_sum;
  logic [DATA_W-1:0]   min_q, max_q;
  logic                smp_vld_q, smp_last_q;
  logic                bad_job, last_rd, more_left, tmo_hit;

  // Ties go to the requester that did not complete the previous job.
  assign grant_d   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  // One extra bit keeps pos+interval from overflowing before the clamp.
  assign end_sum   = pos_q + {1'b0, itv_q};
  assign end_d     = (end_sum > {1'b0, count_q}) ? {1'b0, count_q} : end_sum;
  assign bad_job   = (count_q == '0) || (itv_q == '0);
  assign last_rd   = (pos_q + POS_ONE) == end_q;
  assign more_left = end_q < {1'b0, count_q};

`ifdef MINMAX_SCHED_TIMEOUT_EN
  logic [7:0] tmo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (state_q == WAIT_RES) begin
      tmo_q <= tmo_q + 8'd1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit = (tmo_q == 8'hFF);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    mem_rd_en = 1'b0;
    eng_start = 1'b0;
    res_wr_en = 1'b0;
    done      = 2'b00;
    err       = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = ARB;
      end
      ARB: begin
        if (|req_valid) begin
          req_ready = grant_d ? 2'b10 : 2'b01;
          state_d   = INT_START;
        end else begin
          state_d = IDLE;
        end
      end
      INT_START: begin
        if (bad_job) begin
          err[grant_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          eng_start = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        if (last_rd) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (eng_result_valid) begin
          state_d = WRITE;
        end else if (tmo_hit) begin
          err[grant_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        res_wr_en = 1'b1;
        state_d   = more_left ? INT_START : FINISH;
      end
      FINISH: begin
        done[grant_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      base_q     <= '0;
      rbase_q    <= '0;
      count_q    <= '0;
      itv_q      <= '0;
      k_q        <= '0;
      pos_q      <= '0;
      end_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      smp_vld_q  <= 1'b0;
      smp_last_q <= 1'b0;
    end else begin
      smp_vld_q  <= mem_rd_en;
      smp_last_q <= mem_rd_en & last_rd;
      case (state_q)
        ARB: begin
          if (|req_valid) begin
            grant_q <= grant_d;
            base_q  <= grant_d ? req_base[2*ADDR_W-1:ADDR_W]     : req_base[ADDR_W-1:0];
            rbase_q <= grant_d ? req_res_base[2*ADDR_W-1:ADDR_W] : req_res_base[ADDR_W-1:0];
            count_q <= grant_d ? req_count[2*LEN_W-1:LEN_W]      : req_count[LEN_W-1:0];
            itv_q   <= grant_d ? req_interval[2*LEN_W-1:LEN_W]   : req_interval[LEN_W-1:0];
            k_q     <= '0;
            pos_q   <= '0;
          end
        end
        INT_START: end_q <= end_d;
        FETCH:     pos_q <= pos_q + POS_ONE;
        WAIT_RES: begin
          if (eng_result_valid) begin
            min_q <= eng_min;
            max_q <= eng_max;
          end
        end
        WRITE:     k_q    <= k_q + K_ONE;
        FINISH:    last_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign mem_rd_addr      = base_q + ADDR_W'(pos_q);
  assign eng_sample_valid = smp_vld_q;
  assign eng_sample       = smp_vld_q ? mem_rd_data : '0;
  assign eng_last         = smp_last_q;
  assign res_wr_addr      = rbase_q + ADDR_W'(k_q);
  assign res_wr_data      = {max_q, min_q};
  assign busy             = state_q inside {INT_START, FETCH, WAIT_RES, WRITE, FINISH};
  assign grant_id         = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_minmax_job_scheduler.sv
`default_nettype none
// Testbench for minmax_job_scheduler: RAM and engine stand-ins, a per-job
// interval model of reads/writes/results, and directed plus random jobs.
module tb_minmax_job_scheduler;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] cnt;
    logic [15:0] itv;
    logic [15:0] rb;
  } job_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_base = '0, req_count = '0, req_interval = '0, req_res_base = '0;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        eng_start, eng_sample_valid, eng_last;
  logic [31:0] eng_sample;
  logic        eng_result_valid = 1'b0;
  logic [31:0] eng_min = '0, eng_max = '0;
  logic        res_wr_en;
  logic [15:0] res_wr_addr;
  logic [63:0] res_wr_data;
  logic [1:0]  done, err;
  logic        busy, grant_id;

  minmax_job_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_count(req_count),
    .req_interval(req_interval), .req_res_base(req_res_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .eng_start(eng_start), .eng_sample_valid(eng_sample_valid),
    .eng_sample(eng_sample), .eng_last(eng_last),
    .eng_result_valid(eng_result_valid), .eng_min(eng_min), .eng_max(eng_max),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .done(done), .err(err), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Sample RAM with one-cycle read latency.
  logic [31:0] mem [65536];
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  // Engine stand-in: accumulates min/max, answers eng_lat cycles after eng_last.
  int                 eng_lat = 2;
  logic               eng_silent = 1'b0;
  int                 pend = 0;
  logic signed [31:0] amin = 0, amax = 0, pmin = 0, pmax = 0, es = 0;
  always @(negedge clk) begin
    eng_result_valid = 1'b0;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          eng_result_valid = 1'b1; eng_min = pmin; eng_max = pmax;
        end
      end
      if (eng_start) begin
        amin = 32'sh7fffffff; amax = 32'sh80000000;
      end
      if (eng_sample_valid) begin
        es = signed'(eng_sample);
        if (es < amin) amin = es;
        if (es > amax) amax = es;
        if (eng_last && !eng_silent) begin
          if (eng_lat == 0) begin
            eng_result_valid = 1'b1; eng_min = amin; eng_max = amax;
          end else begin
            pmin = amin; pmax = amax; pend = eng_lat;
          end
        end
      end
    end
  end

  // Observation log.
  int          cyc = 0, obs_starts = 0, obs_samp = 0;
  logic [15:0] obs_rd[$], obs_wr_addr[$];
  logic [63:0] obs_wr_data[$];
  int          obs_last[$], obs_done[$], obs_err[$], obs_err_cyc[$], obs_grant[$], obs_acc_cyc[$];
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (mem_rd_en) obs_rd.push_back(mem_rd_addr);
      if (res_wr_en) begin
        obs_wr_addr.push_back(res_wr_addr);
        obs_wr_data.push_back(res_wr_data);
      end
      if (eng_start) obs_starts++;
      if (eng_sample_valid) begin
        if (eng_last) obs_last.push_back(obs_samp);
        obs_samp++;
      end
      for (int r = 0; r < 2; r++) begin
        if (done[r]) obs_done.push_back(r);
        if (err[r]) begin obs_err.push_back(r); obs_err_cyc.push_back(cyc); end
        if (req_valid[r] && req_ready[r]) begin obs_grant.push_back(r); obs_acc_cyc.push_back(cyc); end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected activity of the current test.
  logic        model_last = 1'b1;
  logic [15:0] exp_rd[$], exp_wr_addr[$];
  logic [63:0] exp_wr_data[$];
  int          exp_last[$], exp_done[$], exp_err[$], exp_grant[$];
  int          exp_starts, exp_samp;
  int          m_rd, m_wr, m_last, m_done, m_err, m_grant, m_starts, m_samp;
  logic [1:0]  drop = '0;

  task automatic begin_test();
    m_rd = obs_rd.size(); m_wr = obs_wr_addr.size(); m_last = obs_last.size();
    m_done = obs_done.size(); m_err = obs_err.size(); m_grant = obs_grant.size();
    m_starts = obs_starts; m_samp = obs_samp;
    exp_rd.delete(); exp_wr_addr.delete(); exp_wr_data.delete(); exp_last.delete();
    exp_done.delete(); exp_err.delete(); exp_grant.delete();
    exp_starts = 0; exp_samp = 0;
  endtask

  task automatic model_job(int r, job_t j);
    int k, hi;
    logic [15:0]        a;
    logic signed [31:0] mn, mx, s;
    if (j.cnt == 0 || j.itv == 0) begin
      exp_err.push_back(r);
      return;
    end
    k = 0;
    for (int lo = 0; lo < int'(j.cnt); lo += int'(j.itv)) begin
      hi = lo + int'(j.itv);
      if (hi > int'(j.cnt)) hi = int'(j.cnt);
      mn = 32'sh7fffffff; mx = 32'sh80000000;
      for (int i = lo; i < hi; i++) begin
        a = 16'(j.base + 16'(i));
        exp_rd.push_back(a);
        s = signed'(mem[a]);
        if (s < mn) mn = s;
        if (s > mx) mx = s;
      end
      exp_last.push_back(exp_samp + hi - lo - 1);
      exp_samp += hi - lo;
      exp_wr_addr.push_back(16'(j.rb + 16'(k)));
      exp_wr_data.push_back({mx, mn});
      k++;
    end
    exp_starts += k;
    exp_done.push_back(r);
    model_last = r[0];
  endtask

  task automatic set_req(int r, job_t j);
    req_base[r*16 +: 16]     = j.base;
    req_count[r*16 +: 16]    = j.cnt;
    req_interval[r*16 +: 16] = j.itv;
    req_res_base[r*16 +: 16] = j.rb;
    req_valid[r]             = 1'b1;
  endtask

  // One cycle; a requester drops valid the cycle after its acceptance.
  task automatic step();
    @(negedge clk);
    req_valid = req_valid & ~drop;
    drop      = req_valid & req_ready;
  endtask

  task automatic drain(string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      step();
      n++;
      if (req_valid == 2'b00 && !busy) quiet++; else quiet = 0;
    end
    chk({tag, " completes"}, quiet >= 3, 1);
  endtask

  task automatic check_test(string tag);
    chk({tag, " read count"}, obs_rd.size() - m_rd, exp_rd.size());
    for (int i = 0; i < exp_rd.size() && m_rd + i < obs_rd.size(); i++)
      chk({tag, " read addr"}, obs_rd[m_rd + i], exp_rd[i]);
    chk({tag, " write count"}, obs_wr_addr.size() - m_wr, exp_wr_addr.size());
    for (int i = 0; i < exp_wr_addr.size() && m_wr + i < obs_wr_addr.size(); i++) begin
      chk({tag, " write addr"}, obs_wr_addr[m_wr + i], exp_wr_addr[i]);
      chk({tag, " write data"}, obs_wr_data[m_wr + i], exp_wr_data[i]);
    end
    chk({tag, " last count"}, obs_last.size() - m_last, exp_last.size());
    for (int i = 0; i < exp_last.size() && m_last + i < obs_last.size(); i++)
      chk({tag, " last position"}, obs_last[m_last + i] - m_samp, exp_last[i]);
    chk({tag, " eng_start count"}, obs_starts - m_starts, exp_starts);
    chk({tag, " done count"}, obs_done.size() - m_done, exp_done.size());
    for (int i = 0; i < exp_done.size() && m_done + i < obs_done.size(); i++)
      chk({tag, " done id"}, obs_done[m_done + i], exp_done[i]);
    chk({tag, " err count"}, obs_err.size() - m_err, exp_err.size());
    for (int i = 0; i < exp_err.size() && m_err + i < obs_err.size(); i++)
      chk({tag, " err id"}, obs_err[m_err + i], exp_err[i]);
    chk({tag, " grant count"}, obs_grant.size() - m_grant, exp_grant.size());
    for (int i = 0; i < exp_grant.size() && m_grant + i < obs_grant.size(); i++)
      chk({tag, " grant order"}, obs_grant[m_grant + i], exp_grant[i]);
  endtask

  task automatic run_single(int r, job_t j, string tag);
    step();
    begin_test();
    set_req(r, j);
    exp_grant.push_back(r);
    model_job(r, j);
    drain(tag);
    check_test(tag);
  endtask

  task automatic run_tie(job_t j0, job_t j1, string tag);
    int w;
    step();
    begin_test();
    set_req(0, j0);
    set_req(1, j1);
    w = model_last ? 0 : 1;
    exp_grant.push_back(w);
    exp_grant.push_back(1 - w);
    model_job(w, w == 0 ? j0 : j1);
    model_job(1 - w, w == 0 ? j1 : j0);
    drain(tag);
    check_test(tag);
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, " control outputs"},
        {req_ready, mem_rd_en, eng_start, eng_sample_valid, eng_last, res_wr_en, done, err, busy, grant_id}, 0);
    chk({tag, " address outputs"}, {mem_rd_addr, res_wr_addr}, 0);
    chk({tag, " data outputs"}, |{eng_sample, res_wr_data}, 0);
  endtask

  initial begin
    job_t j, j1;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    eng_lat = 2;
    run_single(0, '{base: 16'h0010, cnt: 16'd20, itv: 16'd10, rb: 16'h0080}, "basic");

    eng_lat = 1;
    j1 = '{base: 16'($urandom), cnt: 16'($urandom_range(1, 30)), itv: 16'($urandom_range(1, 9)), rb: 16'($urandom)};
    run_tie('{base: 16'h0200, cnt: 16'd25, itv: 16'd10, rb: 16'h0300}, j1, "tie1 short interval");

    eng_lat = 3;
    j  = '{base: 16'($urandom), cnt: 16'($urandom_range(1, 30)), itv: 16'($urandom_range(1, 9)), rb: 16'($urandom)};
    j1 = '{base: 16'($urandom), cnt: 16'($urandom_range(1, 30)), itv: 16'($urandom_range(1, 9)), rb: 16'($urandom)};
    run_tie(j, j1, "tie2");

    run_single(1, '{base: 16'h0040, cnt: 16'd12, itv: 16'd0, rb: 16'h0090}, "zero interval");
    if (obs_err.size() > m_err && obs_acc_cyc.size() > m_grant)
      chk("zero interval err latency", obs_err_cyc[m_err] - obs_acc_cyc[m_grant], 1);
    run_single(0, '{base: 16'h0050, cnt: 16'd0, itv: 16'd4, rb: 16'h00A0}, "zero count");

    for (int t = 0; t < 8; t++) begin
      j = '{base: (t == 0) ? 16'hFFF0 : 16'($urandom), cnt: 16'($urandom_range(1, 40)),
            itv: 16'($urandom_range(1, 12)), rb: (t == 0) ? 16'hFFFE : 16'($urandom)};
      eng_lat = $urandom_range(0, 4);
      run_single($urandom_range(0, 1), j, "random");
    end

    // Asynchronous reset in the middle of sample fetching.
    eng_lat = 2;
    step();
    begin_test();
    set_req(0, '{base: 16'h0400, cnt: 16'd30, itv: 16'd8, rb: 16'h0500});
    for (int n = 0; n < 50 && !mem_rd_en; n++) step();
    repeat (3) step();
    chk("midjob in fetch", mem_rd_en, 1);
    #2 reset = 1'b1;
    #1 check_outputs_zero("midjob reset");
    req_valid = '0;
    drop = '0;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
    repeat (5) step();
    chk("midjob done count", obs_done.size() - m_done, 0);
    chk("midjob err count", obs_err.size() - m_err, 0);
    chk("midjob write count", obs_wr_addr.size() - m_wr, 0);
    run_single(1, '{base: 16'h0600, cnt: 16'd7, itv: 16'd3, rb: 16'h0700}, "after reset");

    // Engine never answers.
    eng_silent = 1'b1;
    step();
    begin_test();
    set_req(1, '{base: 16'h0800, cnt: 16'd4, itv: 16'd4, rb: 16'h0900});
    repeat (300) step();
`ifdef MINMAX_SCHED_TIMEOUT_EN
    chk("silent engine err count", obs_err.size() - m_err, 1);
    chk("silent engine busy", busy, 0);
`else
    chk("silent engine err count", obs_err.size() - m_err, 0);
    chk("silent engine busy", busy, 1);
`endif
    chk("silent engine write count", obs_wr_addr.size() - m_wr, 0);
    chk("silent engine done count", obs_done.size() - m_done, 0);
    reset = 1'b1;
    eng_silent = 1'b0;
    req_valid = '0;
    drop = '0;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
